// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC result-memory reader.
package mfcc_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int FRAME_W     = 8;
    localparam int COEF_W      = 6;
    localparam int FIRST_FRAME = 2;
    localparam int FRAME_TAIL  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mfcc_result_reader_if.sv
// Result word stream (valid/ready) from the reader to the host/DMA side.
interface mfcc_result_reader_if #(
    parameter int DATA_WIDTH = mfcc_pkg::DATA_WIDTH,
    parameter int FRAME_W    = mfcc_pkg::FRAME_W,
    parameter int COEF_W     = mfcc_pkg::COEF_W
);
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [FRAME_W-1:0]    res_frame;
    logic [COEF_W-1:0]     res_coef;
    logic                  res_last;

    modport master (
        output res_valid, res_data, res_frame, res_coef, res_last,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_data, res_frame, res_coef, res_last,
        output res_ready
    );
endinterface

// File: rtl/mfcc_res_fifo2.sv
// Two-entry FIFO for tagged result words; head is always presented, occupancy exported.
module mfcc_res_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
        end
    end

    assign head = mem_q[rd_q];
    assign occ  = occ_q;
endmodule

// File: rtl/mfcc_result_reader.sv
// Takes the MFCC result memory over after finish_flag rises and streams frames 2..frame_num-3
// out over valid/ready, coefficient fastest.
//   state  | meaning
//   IDLE   | core owns the port, waiting for a finish_flag rising edge
//   SETTLE | port taken, down-counting settle cycles before the first address
//   READ   | issuing addresses while FIFO credit allows
//   DRAIN  | all addresses issued, waiting for in-flight read and FIFO to empty
//   DONE   | one-cycle done pulse, port handed back to the core
module mfcc_result_reader
    import mfcc_pkg::*;
#(
    parameter int DATA_WIDTH    = mfcc_pkg::DATA_WIDTH,
    parameter int FRAME_W       = mfcc_pkg::FRAME_W,
    parameter int COEF_W        = mfcc_pkg::COEF_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      finish_flag,
    input  logic [6:0]                frame_num,
    input  logic [6:0]                cep_num,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [FRAME_W+COEF_W-1:0] mem_addr,
    output logic                      mem_addr_sel,
    output logic                      mem_cen_sel,
    output logic                      mem_wen_in,
    mfcc_result_reader_if.master      res,
    output logic                      busy,
    output logic                      done
);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ENT_W = DATA_WIDTH + FRAME_W + COEF_W + 1;
    localparam int C_MAX = (1 << COEF_W) - 1;

    state_t             state_q, state_d;
    logic               fin_q, fin_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [FRAME_W-1:0] frame_q, frame_d, f_end_q, f_end_d;
    logic [COEF_W-1:0]  coef_q, coef_d, c_end_q, c_end_d;
    logic               empty_q, empty_d;
    logic               infl_q, infl_d;
    logic [FRAME_W-1:0] infl_frame_q, infl_frame_d;
    logic [COEF_W-1:0]  infl_coef_q, infl_coef_d;
    logic               infl_last_q, infl_last_d;

    logic [7:0]         c_raw;
    logic [1:0]         occ;
    logic [2:0]         in_use;
    logic               pop, issue, last_addr;
    logic [ENT_W-1:0]   head;

    assign c_raw     = {cep_num, 1'b1};
    assign pop       = res.res_valid & res.res_ready;
    // Slots already claimed once this cycle's pop is accounted for; the FIFO can never overflow.
    assign in_use    = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
    assign issue     = (state_q == ST_READ) && (in_use < 3'd2);
    assign last_addr = (frame_q == f_end_q) && (coef_q == c_end_q);

    always_comb begin
        state_d      = state_q;
        fin_d        = finish_flag;
        settle_d     = settle_q;
        frame_d      = frame_q;
        coef_d       = coef_q;
        f_end_d      = f_end_q;
        c_end_d      = c_end_q;
        empty_d      = empty_q;
        infl_d       = issue;
        infl_frame_d = infl_frame_q;
        infl_coef_d  = infl_coef_q;
        infl_last_d  = infl_last_q;

        if (issue) begin
            infl_frame_d = frame_q;
            infl_coef_d  = coef_q;
            infl_last_d  = last_addr;
        end

        case (state_q)
            ST_IDLE: begin
                if (finish_flag && !fin_q) begin
                    state_d  = ST_SETTLE;
                    settle_d = SET_W'(SETTLE_CYCLES - 1);
                    f_end_d  = FRAME_W'(frame_num) - FRAME_W'(FRAME_TAIL);
                    c_end_d  = (int'(c_raw) > C_MAX) ? COEF_W'(C_MAX) : COEF_W'(c_raw);
                    empty_d  = frame_num < 7'(FIRST_FRAME + FRAME_TAIL);
                    frame_d  = FRAME_W'(FIRST_FRAME);
                    coef_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = empty_q ? ST_DONE : ST_READ;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (coef_q == c_end_q) begin
                        coef_d  = '0;
                        frame_d = frame_q + 1'b1;
                    end else begin
                        coef_d = coef_q + 1'b1;
                    end
                    if (last_addr) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!infl_q && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fin_q        <= 1'b0;
            settle_q     <= '0;
            frame_q      <= '0;
            coef_q       <= '0;
            f_end_q      <= '0;
            c_end_q      <= '0;
            empty_q      <= 1'b0;
            infl_q       <= 1'b0;
            infl_frame_q <= '0;
            infl_coef_q  <= '0;
            infl_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fin_q        <= fin_d;
            settle_q     <= settle_d;
            frame_q      <= frame_d;
            coef_q       <= coef_d;
            f_end_q      <= f_end_d;
            c_end_q      <= c_end_d;
            empty_q      <= empty_d;
            infl_q       <= infl_d;
            infl_frame_q <= infl_frame_d;
            infl_coef_q  <= infl_coef_d;
            infl_last_q  <= infl_last_d;
        end
    end

    mfcc_res_fifo2 #(.W(ENT_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl_q),
        .push_data ({mem_rdata, infl_frame_q, infl_coef_q, infl_last_q}),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign {res.res_data, res.res_frame, res.res_coef, res.res_last} = head;
    assign res.res_valid = (occ != 2'd0);

    assign mem_addr     = {frame_q, coef_q};
    assign mem_addr_sel = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign mem_cen_sel  = 1'b1;
    assign mem_wen_in   = 1'b0;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
endmodule

// File: tb/tb_mfcc_result_reader.sv
// Scoreboard bench for mfcc_result_reader: directed sweeps, expected words queued at start,
// negedge monitor pops and compares each transfer.
module tb_mfcc_result_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        finish_flag = 1'b0;
    logic [6:0]  frame_num = 7'd0;
    logic [6:0]  cep_num = 7'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic [13:0] mem_addr;
    logic        mem_addr_sel, mem_cen_sel, mem_wen_in, busy, done;

    mfcc_result_reader_if #(.DATA_WIDTH(32), .FRAME_W(8), .COEF_W(6)) res_if ();

    mfcc_result_reader #(
        .DATA_WIDTH(32), .FRAME_W(8), .COEF_W(6), .SETTLE_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .finish_flag  (finish_flag),
        .frame_num    (frame_num),
        .cep_num      (cep_num),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_addr_sel (mem_addr_sel),
        .mem_cen_sel  (mem_cen_sel),
        .mem_wen_in   (mem_wen_in),
        .res          (res_if),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [13:0] a);
        return {4'hA, a, ~a};
    endfunction

    // Result memory with one cycle of read latency.
    always @(posedge clk) mem_rdata <= word_of(mem_addr);

    bit rnd_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        res_if.res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  f;
        logic [5:0]  c;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    int   xfer_cnt = 0, done_cnt = 0, first_valid_cyc = -1, last_xfer_cyc = -1, sweep_words = 0;
    logic prev_stall = 1'b0;
    exp_t prev_w, cur_w, exp_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur_w = {res_if.res_data, res_if.res_frame, res_if.res_coef, res_if.res_last};
            if (prev_stall)
                check("stall_hold", {16'b0, res_if.res_valid, cur_w}, {16'b0, 1'b1, prev_w});
            if (res_if.res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (res_if.res_valid && res_if.res_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got %0h expected none", cur_w);
                end else begin
                    exp_w = sb.pop_front();
                    check("word", 64'(cur_w), 64'(exp_w));
                end
                xfer_cnt++;
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done_sel", 64'(mem_addr_sel), 64'd1);
                if (sweep_words > 0) check("done_lat", 64'(cyc), 64'(last_xfer_cyc + 1));
            end
            prev_stall = res_if.res_valid && !res_if.res_ready;
            prev_w     = cur_w;
        end
    end

    task automatic push_expected(input int fn, input int cn);
        int ce, fe;
        ce = 2 * cn + 1;
        if (ce > 63) ce = 63;
        fe = fn - 3;
        for (int f = 2; f <= fe; f++)
            for (int c = 0; c <= ce; c++)
                sb.push_back({word_of({8'(f), 6'(c)}), 8'(f), 6'(c), 1'(f == fe && c == ce)});
    endtask

    task automatic wait_done(input int d0, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != d0) break;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic run_sweep(input int fn, input int cn, input bit rnd, input int exp_words,
                             input bit gapless, input bit poke);
        int x0, d0, t0;
        push_expected(fn, cn);
        rnd_ready       = rnd;
        sweep_words     = exp_words;
        first_valid_cyc = -1;
        x0 = xfer_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        frame_num   = 7'(fn);
        cep_num     = 7'(cn);
        finish_flag = 1'b1;
        t0 = cyc;
        if (poke) begin
            repeat (20) @(posedge clk);
            #1;
            finish_flag = 1'b0;
            frame_num   = 7'd30;
            cep_num     = 7'd1;
            repeat (3) @(posedge clk);
            #1;
            finish_flag = 1'b1;
        end
        wait_done(d0, 20000);
        check("words", 64'(xfer_cnt - x0), 64'(exp_words));
        check("sb_empty", 64'(sb.size()), 64'd0);
        if (exp_words > 0) check("first_lat", 64'(first_valid_cyc - t0), 64'd5);
        else check("no_valid", 64'(first_valid_cyc), 64'(-1));
        if (gapless) check("gapless", 64'(last_xfer_cyc - first_valid_cyc), 64'(exp_words - 1));
        if (poke) repeat (10) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_sel", 64'(mem_addr_sel), 64'd1);
        finish_flag = 1'b0;
        rnd_ready   = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_sel"},   64'(mem_addr_sel), 64'd1);
        check({tag, "_cen"},   64'(mem_cen_sel), 64'd1);
        check({tag, "_wen"},   64'(mem_wen_in), 64'd0);
        check({tag, "_valid"}, 64'(res_if.res_valid), 64'd0);
        check({tag, "_last"},  64'(res_if.res_last), 64'd0);
        check({tag, "_data"},  64'(res_if.res_data), 64'd0);
        check({tag, "_frame"}, 64'(res_if.res_frame), 64'd0);
        check({tag, "_coef"},  64'(res_if.res_coef), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
    endtask

    initial begin
        int x0, d0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_sweep(24, 31, 1'b0, 1280, 1'b1, 1'b0);
        run_sweep(24, 31, 1'b1, 1280, 1'b0, 1'b0);
        run_sweep(4,  31, 1'b0, 0,    1'b0, 1'b0);
        run_sweep(6,  40, 1'b0, 128,  1'b1, 1'b0);
        run_sweep(8,  5,  1'b0, 48,   1'b1, 1'b1);

        // Reset in the middle of a sweep, then a fresh sweep.
        push_expected(24, 31);
        sweep_words = 1280;
        x0 = xfer_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        frame_num   = 7'd24;
        cep_num     = 7'd31;
        finish_flag = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (xfer_cnt - x0 >= 500) break;
        end
        check("reached_500", 64'(xfer_cnt - x0), 64'd500);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        sb.delete();
        finish_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("no_done_on_reset", 64'(done_cnt - d0), 64'd0);
        run_sweep(6, 2, 1'b0, 12, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mfcc_result_reader.md
# mfcc_result_reader

Hardware reader for the MFCC result memory: it replaces the bench-side readout loop that runs after `finish_flag`. It detects the rising edge of `finish_flag` and takes the result-memory port away from the core. It then sweeps addresses {frame, coef} over frames 2..frame_num-3 and coefficients 0..2*cep_num+1, and streams each word out on a valid/ready interface. It sits between `top` (result memory port, `result_data_out`, `finish_flag`) and the host/DMA side.

## Interface
- `DATA_WIDTH`, 32: result word width.
- `FRAME_W`, 8: frame index width (address high part).
- `COEF_W`, 6: coefficient index width (address low part).
- `SETTLE_CYCLES`, 2: idle cycles between port takeover and first address.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `finish_flag` in 1: MFCC core done, level from `top`.
- `frame_num` in 7: total frames; sampled at start.
- `cep_num` in 7: cepstrum count; sampled at start.
- `mem_rdata` in DATA_WIDTH: `result_data_out` from `top`.
- `mem_addr` out FRAME_W+COEF_W: drives `system_result_4_mem_addr`.
- `mem_addr_sel` out 1: drives `system_result_4_mem_addr_sel`; 1 = core owns the port, 0 = reader owns it.
- `mem_cen_sel` out 1: constant 1.
- `mem_wen_in` out 1: constant 0.
- `res_valid` out 1: output word valid.
- `res_ready` in 1: consumer accepts.
- `res_data` out DATA_WIDTH: result word.
- `res_frame` out FRAME_W: frame index of the word.
- `res_coef` out COEF_W: coefficient index of the word.
- `res_last` out 1: final word of the sweep.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- **Reset values:**
  - `mem_addr` = 0, `mem_addr_sel` = 1, `mem_cen_sel` = 1, `mem_wen_in` = 0.
  - `res_valid`/`res_last`/`busy`/`done` = 0; `res_data`/`res_frame`/`res_coef` = 0.
  - FIFO empty, state IDLE.
- **Start:** `finish_flag` is registered; a rising edge (0 then 1) in IDLE starts a sweep. At start:
  - `f_end` = frame_num-3 is latched.
  - `c_end` = min(2*cep_num+1, 2^COEF_W-1) is latched.
  - Frame counter is set to 2, coefficient counter to 0.
- **States:**
  - IDLE -> SETTLE on start; `mem_addr_sel` drops to 0 on entry.
  - SETTLE counts SETTLE_CYCLES, then -> READ.
  - READ issues addresses, coefficient fastest. After issuing (f_end, c_end) -> DRAIN.
  - DRAIN waits until the in-flight read is done and the FIFO is empty -> DONE.
  - DONE pulses `done` for one cycle, restores `mem_addr_sel` = 1, then -> IDLE.
- **Empty sweep:** if frame_num < 5, SETTLE goes directly to DONE; no words are produced.
- **Address:** `mem_addr` = {frame[FRAME_W-1:0], coef[COEF_W-1:0]}, registered. When the coefficient reaches `c_end`, it wraps to 0 and the frame increments.
- **Memory:** read latency is 1 cycle. Data for the address driven in cycle k is sampled in cycle k+1, together with its pipelined frame/coef/last tags.
- **Buffering:** 2-entry FIFO holding {data, frame, coef, last}.
  - An address is issued only if (FIFO occupancy − pop this cycle + in-flight) < 2. The FIFO therefore never overflows, and `res_ready` backpressure stalls address issue.
- **Handshake:**
  - A word transfers when `res_valid` & `res_ready`.
  - `res_*` hold stable while `res_valid` is high and `res_ready` is low.
  - `res_valid` never drops without a transfer.
- **Ignored events:** `finish_flag` edges outside IDLE have no effect. `frame_num`/`cep_num` changes mid-sweep are ignored because both are latched at start.
- **Reset mid-sweep:** returns immediately to the reset values. The FIFO is flushed, no `done` pulse is issued, and the port is returned to the core.

## Timing
- Edge detected in cycle T: SETTLE covers T+1..T+S (S = SETTLE_CYCLES).
- First address is driven in T+S+1; first `res_valid` is in T+S+3.
- With `res_ready` held at 1: one word per cycle, no bubbles.
- `done` fires 1 cycle after the `res_last` transfer; `mem_addr_sel` = 1 in the same cycle as `done`.
- Words per sweep = (frame_num-4) × (c_end+1).

## Structure
- Shared package `mfcc_pkg`:
  - State enum IDLE/SETTLE/READ/DRAIN/DONE.
  - Widths FRAME_W/COEF_W/DATA_WIDTH.
  - Constant FIRST_FRAME = 2, frame tail offset = 3.
- Sub-module `mfcc_res_fifo2`: 2-entry FIFO with occupancy output.
- The FSM, counters and issue credit logic stay in the top of the block.

## Test plan
- frame_num=24, cep_num=31, `res_ready`=1:
  - 1280 words, frames 2..21, coefs 0..63.
  - First word at address 0x080 (frame 2, coef 0); last at 0x57F (frame 21, coef 63) with `res_last`.
  - Gapless stream; `done` 1 cycle after the last transfer.
- Same configuration with `res_ready` randomly toggled:
  - Identical ordered data, no duplicates or drops.
  - `res_*` stable during stalls.
- frame_num=4: no `res_valid`; `done` pulses; `mem_addr_sel` returns to 1.
- cep_num=40: `c_end` clamps to 63; 64 words per frame.
- Second `finish_flag` pulse mid-sweep: ignored, word count unchanged.
- `rst_n` asserted at word 500: all outputs go to reset values asynchronously, FIFO is flushed. After release, a new `finish_flag` edge restarts the sweep from frame 2, coef 0.
